// File: rtl/cpu_pkg.sv
// cpu_pkg: shared reset vector, PC-select encoding and sequencer FSM states.
package cpu_pkg;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_J, SEL_JR} pc_sel_t;
   typedef enum logic {ST_IDLE, ST_PENDING} pc_state_t;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority redirect mux (jr > jump > branch > sequential) and target arithmetic.
import cpu_pkg::*;

module pc_next_sel (
   input  logic [31:0] pc_plus4,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic        jr,
   input  logic [31:0] rs_value,
   input  logic [31:0] jump_target,
   output pc_sel_t     sel,
   output logic [31:0] target,
   output logic        bad_align
);
   always_comb begin
      sel = jr ? SEL_JR : jump ? SEL_J : branch_taken ? SEL_BR : SEL_SEQ;
      target = sel == SEL_JR ? {rs_value[31:2], 2'b00} :
               sel == SEL_J  ? jump_target :
               sel == SEL_BR ? pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00} :
               pc_plus4;
      bad_align = jr && rs_value[1:0] != 2'b00;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, next-PC sequencing and JAL link generation.
// Define PC_DELAY_SLOT_EN for a MIPS branch delay slot (IDLE/PENDING FSM).
import cpu_pkg::*;

module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter int          PC_W         = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [15:0]     branch_imm,
   input  logic            jump,
   input  logic            jal,
   input  logic            jr,
   input  logic [PC_W-1:0] rs_value,
   input  logic [PC_W-1:0] jump_target,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus4,
   output logic [3:0]      pc_hi,
   output logic            link_we,
   output logic [PC_W-1:0] link_addr,
   output logic            misalign
);
   pc_sel_t     sel;
   logic [31:0] target;
   logic        bad_align;
   logic        advance;

   assign advance  = !stall;
   assign pc_plus4 = pc + 32'd4;
   assign pc_hi    = pc_plus4[31:28];

   pc_next_sel u_sel (
      .pc_plus4    (pc_plus4),
      .branch_taken(branch_taken),
      .branch_imm  (branch_imm),
      .jump        (jump),
      .jr          (jr),
      .rs_value    (rs_value),
      .jump_target (jump_target),
      .sel         (sel),
      .target      (target),
      .bad_align   (bad_align)
   );

`ifdef PC_DELAY_SLOT_EN
   pc_state_t   state;
   logic [31:0] pend_tgt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc        <= RESET_VECTOR;
         link_we   <= 1'b0;
         link_addr <= '0;
         misalign  <= 1'b0;
         state     <= ST_IDLE;
         pend_tgt  <= '0;
      end else begin
         link_we  <= 1'b0;
         misalign <= 1'b0;
         if (advance) begin
            if (state == ST_PENDING) begin
               pc    <= pend_tgt;
               state <= ST_IDLE;
            end else begin
               pc       <= pc_plus4;
               misalign <= bad_align;
               if (sel != SEL_SEQ) begin
                  pend_tgt <= target;
                  state    <= ST_PENDING;
               end
               // return past the delay slot instruction
               if (sel == SEL_J && jal) begin
                  link_we   <= 1'b1;
                  link_addr <= pc_plus4 + 32'd4;
               end
            end
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc        <= RESET_VECTOR;
         link_we   <= 1'b0;
         link_addr <= '0;
         misalign  <= 1'b0;
      end else begin
         link_we  <= 1'b0;
         misalign <= 1'b0;
         if (advance) begin
            pc       <= target;
            misalign <= bad_align;
            if (sel == SEL_J && jal) begin
               link_we   <= 1'b1;
               link_addr <= pc_plus4;
            end
         end
      end
   end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer, honouring PC_DELAY_SLOT_EN when defined.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst_n, stall, branch_taken, jump, jal, jr;
   logic [15:0] branch_imm;
   logic [31:0] rs_value, jump_target;
   logic [31:0] pc, pc_plus4, link_addr;
   logic [3:0]  pc_hi;
   logic        link_we, misalign;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_imm(branch_imm), .jump(jump), .jal(jal), .jr(jr),
      .rs_value(rs_value), .jump_target(jump_target), .pc(pc),
      .pc_plus4(pc_plus4), .pc_hi(pc_hi), .link_we(link_we),
      .link_addr(link_addr), .misalign(misalign)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_pc(input logic [31:0] v);
      jr = 1'b1;
      rs_value = v;
      tick();
      jr = 1'b0;
`ifdef PC_DELAY_SLOT_EN
      tick();
`endif
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b1; jump = 1'b0; jal = 1'b0; jr = 1'b0;
      branch_imm = 16'h0010; rs_value = '0; jump_target = '0;
      tick();
      tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_link_we", {31'b0, link_we}, 32'h0);
      chk("rst_link_addr", link_addr, 32'h0);
      chk("rst_misalign", {31'b0, misalign}, 32'h0);
      chk("rst_pc_plus4", pc_plus4, 32'h4);
      rst_n = 1'b1; branch_taken = 1'b0;
      tick(); chk("seq1", pc, 32'h4);
      tick(); chk("seq2", pc, 32'h8);
      tick(); chk("seq3", pc, 32'hC);

      set_pc(32'h3000_0010);
      chk("setpc", pc, 32'h3000_0010);
      chk("pc_hi", {28'b0, pc_hi}, 32'h3);
      jump = 1'b1; jump_target = 32'h3B57_10FC;
      tick();
      jump = 1'b0;
`ifdef PC_DELAY_SLOT_EN
      chk("j_slot", pc, 32'h3000_0014);
      tick();
`endif
      chk("j_pc", pc, 32'h3B57_10FC);
      chk("j_no_link", {31'b0, link_we}, 32'h0);

      set_pc(32'h3000_0010);
      jump = 1'b1; jal = 1'b1;
      tick();
      jump = 1'b0; jal = 1'b0;
      chk("jal_we", {31'b0, link_we}, 32'h1);
`ifdef PC_DELAY_SLOT_EN
      chk("jal_addr", link_addr, 32'h3000_0018);
      chk("jal_slot", pc, 32'h3000_0014);
      tick();
      chk("jal_pc", pc, 32'h3B57_10FC);
      chk("jal_pulse", {31'b0, link_we}, 32'h0);
`else
      chk("jal_addr", link_addr, 32'h3000_0014);
      chk("jal_pc", pc, 32'h3B57_10FC);
      tick();
      chk("jal_pulse", {31'b0, link_we}, 32'h0);
      chk("jal_addr_hold", link_addr, 32'h3000_0014);
`endif

      set_pc(32'h0000_0100);
      branch_taken = 1'b1; branch_imm = 16'hFFFE;
      tick();
      branch_taken = 1'b0;
`ifdef PC_DELAY_SLOT_EN
      tick();
`endif
      chk("br_neg", pc, 32'h0000_00FC);
      set_pc(32'h0000_0100);
      branch_taken = 1'b1; branch_imm = 16'h0003;
      tick();
      branch_taken = 1'b0;
`ifdef PC_DELAY_SLOT_EN
      tick();
`endif
      chk("br_pos", pc, 32'h0000_0110);

      set_pc(32'h0000_0500);
      jr = 1'b1; jump = 1'b1; branch_taken = 1'b1; rs_value = 32'h0000_2003;
      jump_target = 32'h0000_7000; branch_imm = 16'h0005;
      tick();
      jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      chk("mis_set", {31'b0, misalign}, 32'h1);
`ifdef PC_DELAY_SLOT_EN
      chk("prio_slot", pc, 32'h0000_0504);
      tick();
      chk("prio_pc", pc, 32'h0000_2000);
      chk("mis_clr", {31'b0, misalign}, 32'h0);
      tick();
`else
      chk("prio_pc", pc, 32'h0000_2000);
      tick();
      chk("mis_clr", {31'b0, misalign}, 32'h0);
`endif
      chk("prio_seq", pc, 32'h0000_2004);

      stall = 1'b1; jump = 1'b1; jal = 1'b1; jump_target = 32'h0000_9000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", pc, 32'h0000_2004);
         chk("stall_we", {31'b0, link_we}, 32'h0);
      end
      stall = 1'b0; jump = 1'b0; jal = 1'b0;
      tick();
      chk("unstall", pc, 32'h0000_2008);

      jal = 1'b1;
      tick();
      jal = 1'b0;
      chk("jal_nojump", {31'b0, link_we}, 32'h0);
      chk("jal_nojump_pc", pc, 32'h0000_200C);

      set_pc(32'hFFFF_FFFC);
      chk("wrap_p4", pc_plus4, 32'h0);
      chk("wrap_hi", {28'b0, pc_hi}, 32'h0);
      tick();
      chk("wrap_pc", pc, 32'h0);

`ifdef PC_DELAY_SLOT_EN
      set_pc(32'h0000_0040);
      branch_taken = 1'b1; branch_imm = 16'h000F;
      tick();
      chk("ds_slot", pc, 32'h0000_0044);
      branch_imm = 16'h0001;
      tick();
      branch_taken = 1'b0;
      chk("ds_tgt", pc, 32'h0000_0080);
      tick();
      chk("ds_ignored", pc, 32'h0000_0084);
      set_pc(32'h0000_0040);
      branch_taken = 1'b1; branch_imm = 16'h000F;
      tick();
      branch_taken = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("ds_rst", pc, 32'h0);
      rst_n = 1'b1;
      tick();
      chk("ds_rst_idle", pc, 32'h4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
